// File: rtl/toy_plic_lite.sv
// toy_plic_lite: two-context PLIC with per-source level gateways and a valid/ready register port
module toy_plic_lite #(
    parameter int SRC_NUM = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SRC_NUM-1:0] irq_src,
    input  logic               reg_req_vld,
    output logic               reg_req_rdy,
    input  logic               reg_req_wr,
    input  logic [11:0]        reg_req_addr,
    input  logic [31:0]        reg_req_wdata,
    output logic               reg_rsp_vld,
    input  logic               reg_rsp_rdy,
    output logic [31:0]        reg_rsp_rdata,
    output logic               intr_meip,
    output logic               intr_seip
);
    typedef enum logic [1:0] {IDLE, PEND, CLAIMED} gw_e;
    localparam logic [4:0] MAX_ID = 5'(SRC_NUM);

    gw_e               st    [SRC_NUM:1];
    gw_e               st_nx [SRC_NUM:1];
    logic [PRIO_W-1:0] prio  [32];
    logic [SRC_NUM:1]  en    [2];
    logic [PRIO_W-1:0] thr   [2];
    logic [4:0]        best  [2];
    logic [PRIO_W-1:0] best_p [2];
    logic [SRC_NUM:1]  pend;
    logic [9:0]        word;
    logic [4:0]        pid;
    logic [4:0]        clm_id;
    logic [4:0]        cmp_id;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic              prio_hit;
    logic [31:0]       rd_val;
    logic              unused;

    assign word        = reg_req_addr[11:2];
    assign pid         = word[4:0];
    assign reg_req_rdy = ~reg_rsp_vld;
    assign acc         = reg_req_vld && reg_req_rdy;
    assign wr_acc      = acc && reg_req_wr;
    assign rd_acc      = acc && !reg_req_wr;
    assign prio_hit    = word[9:5] == 5'd0 && pid != 5'd0 && pid <= MAX_ID;
    assign clm_id      = !rd_acc ? 5'd0 : word == 10'h081 ? best[0] : word == 10'h0C1 ? best[1] : 5'd0;
    assign cmp_id      = wr_acc && (word == 10'h081 || word == 10'h0C1) ? reg_req_wdata[4:0] : 5'd0;
    assign unused      = ^{reg_req_addr[1:0], reg_req_wdata};

    // strict '>' keeps the lowest ID on equal priorities
    always_comb begin
        for (int i = 1; i <= SRC_NUM; i++)
            pend[i] = st[i] == PEND;
        for (int c = 0; c < 2; c++) begin
            best[c]   = 5'd0;
            best_p[c] = '0;
            for (int i = 1; i <= SRC_NUM; i++)
                if (pend[i] && en[c][i] && prio[i] > thr[c] && prio[i] > best_p[c]) begin
                    best[c]   = 5'(i);
                    best_p[c] = prio[i];
                end
        end
    end

    always_comb
        for (int i = 1; i <= SRC_NUM; i++)
            st_nx[i] = st[i] == IDLE && irq_src[i-1]       ? PEND    :
                       st[i] == PEND && clm_id == 5'(i)    ? CLAIMED :
                       st[i] == CLAIMED && cmp_id == 5'(i) ? IDLE    : st[i];

    always_comb
        rd_val = prio_hit         ? 32'(prio[pid])       :
                 word == 10'h020 ? 32'({pend, 1'b0})    :
                 word == 10'h040 ? 32'({en[0], 1'b0})   :
                 word == 10'h041 ? 32'({en[1], 1'b0})   :
                 word == 10'h080 ? 32'(thr[0])          :
                 word == 10'h081 ? 32'(best[0])         :
                 word == 10'h0C0 ? 32'(thr[1])          :
                 word == 10'h0C1 ? 32'(best[1])         : 32'd0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 1; i <= SRC_NUM; i++)
                st[i] <= IDLE;
            for (int i = 0; i < 32; i++)
                prio[i] <= '0;
            en[0]         <= '0;
            en[1]         <= '0;
            thr[0]        <= '0;
            thr[1]        <= '0;
            reg_rsp_vld   <= 1'b0;
            reg_rsp_rdata <= '0;
            intr_meip     <= 1'b0;
            intr_seip     <= 1'b0;
        end else begin
            st        <= st_nx;
            intr_meip <= best[0] != 5'd0;
            intr_seip <= best[1] != 5'd0;
            if (acc) begin
                reg_rsp_vld   <= 1'b1;
                reg_rsp_rdata <= reg_req_wr ? 32'd0 : rd_val;
            end else if (reg_rsp_rdy)
                reg_rsp_vld <= 1'b0;
            if (wr_acc && prio_hit)
                prio[pid] <= reg_req_wdata[PRIO_W-1:0];
            if (wr_acc && word == 10'h040)
                en[0] <= reg_req_wdata[SRC_NUM:1];
            if (wr_acc && word == 10'h041)
                en[1] <= reg_req_wdata[SRC_NUM:1];
            if (wr_acc && word == 10'h080)
                thr[0] <= reg_req_wdata[PRIO_W-1:0];
            if (wr_acc && word == 10'h0C0)
                thr[1] <= reg_req_wdata[PRIO_W-1:0];
        end
endmodule

// File: tb/tb_toy_plic_lite.sv
// tb_toy_plic_lite: register table plus interrupt sequences, responses checked through a scoreboard
module tb_toy_plic_lite;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq_src = '0;
    logic        reg_req_vld = 1'b0;
    logic        reg_req_rdy;
    logic        reg_req_wr = 1'b0;
    logic [11:0] reg_req_addr = '0;
    logic [31:0] reg_req_wdata = '0;
    logic        reg_rsp_vld;
    logic        reg_rsp_rdy = 1'b1;
    logic [31:0] reg_rsp_rdata;
    logic        intr_meip;
    logic        intr_seip;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    string       nm_q [$];

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [25];

    toy_plic_lite dut (
        .clk(clk), .rst_n(rst_n), .irq_src(irq_src),
        .reg_req_vld(reg_req_vld), .reg_req_rdy(reg_req_rdy), .reg_req_wr(reg_req_wr),
        .reg_req_addr(reg_req_addr), .reg_req_wdata(reg_req_wdata),
        .reg_rsp_vld(reg_rsp_vld), .reg_rsp_rdy(reg_rsp_rdy), .reg_rsp_rdata(reg_rsp_rdata),
        .intr_meip(intr_meip), .intr_seip(intr_seip)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void sb_pop_chk();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: response 0x%0h with nothing expected", reg_rsp_rdata);
        end else
            chk(nm_q.pop_front(), reg_rsp_rdata, exp_q.pop_front());
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, input string nm);
        int n = 0;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        reg_req_vld   = 1'b1;
        reg_req_wr    = wr;
        reg_req_addr  = a;
        reg_req_wdata = wd;
        reg_rsp_rdy   = 1'b1;
        while (!reg_req_rdy && n < 20) begin
            tick();
            n++;
        end
        tick();
        reg_req_vld = 1'b0;
        while (!reg_rsp_vld && n < 20) begin
            tick();
            n++;
        end
        if (reg_rsp_vld)
            sb_pop_chk();
        else begin
            checks++;
            errors++;
            void'(exp_q.pop_front());
            $display("FAIL %s: response timeout, got none, expected 0x%0h", nm, exp);
            void'(nm_q.pop_front());
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 12'h004, 32'hFFFF_FFFF, 32'h0};
        tbl[1]  = '{1'b0, 12'h004, 32'h0, 32'h7};
        tbl[2]  = '{1'b0, 12'h006, 32'h0, 32'h7};
        tbl[3]  = '{1'b1, 12'h000, 32'h5, 32'h0};
        tbl[4]  = '{1'b0, 12'h000, 32'h0, 32'h0};
        tbl[5]  = '{1'b1, 12'h100, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{1'b0, 12'h100, 32'h0, 32'h1FE};
        tbl[7]  = '{1'b1, 12'h104, 32'h155, 32'h0};
        tbl[8]  = '{1'b0, 12'h104, 32'h0, 32'h154};
        tbl[9]  = '{1'b1, 12'h200, 32'h1D, 32'h0};
        tbl[10] = '{1'b0, 12'h200, 32'h0, 32'h5};
        tbl[11] = '{1'b1, 12'h300, 32'h2, 32'h0};
        tbl[12] = '{1'b0, 12'h300, 32'h0, 32'h2};
        tbl[13] = '{1'b1, 12'h024, 32'h3, 32'h0};
        tbl[14] = '{1'b0, 12'h024, 32'h0, 32'h0};
        tbl[15] = '{1'b1, 12'h400, 32'hFFFF, 32'h0};
        tbl[16] = '{1'b0, 12'h400, 32'h0, 32'h0};
        tbl[17] = '{1'b0, 12'h080, 32'h0, 32'h0};
        tbl[18] = '{1'b0, 12'h204, 32'h0, 32'h0};
        tbl[19] = '{1'b0, 12'h084, 32'h0, 32'h0};
        tbl[20] = '{1'b1, 12'h004, 32'h0, 32'h0};
        tbl[21] = '{1'b1, 12'h100, 32'h0, 32'h0};
        tbl[22] = '{1'b1, 12'h104, 32'h0, 32'h0};
        tbl[23] = '{1'b1, 12'h200, 32'h0, 32'h0};
        tbl[24] = '{1'b0, 12'h100, 32'h0, 32'h0};

        repeat (3) tick();
        chk("rst_meip", 32'(intr_meip), 32'd0);
        chk("rst_seip", 32'(intr_seip), 32'd0);
        chk("rst_rsp_vld", 32'(reg_rsp_vld), 32'd0);
        chk("rst_rdata", reg_rsp_rdata, 32'd0);
        chk("rst_req_rdy", 32'(reg_req_rdy), 32'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 25; i++)
            xact(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp, $sformatf("tbl%0d", i));

        // single source to ctx0: pending one cycle later, interrupt two cycles later
        xact(1'b1, 12'h00C, 32'd2, 32'd0, "w_prio3");
        xact(1'b1, 12'h100, 32'h08, 32'd0, "w_en0");
        xact(1'b1, 12'h200, 32'd0, 32'd0, "w_thr0");
        irq_src = 8'h04;
        tick();
        chk("meip_n1", 32'(intr_meip), 32'd0);
        tick();
        chk("meip_n2", 32'(intr_meip), 32'd1);
        chk("seip_n2", 32'(intr_seip), 32'd0);
        xact(1'b0, 12'h080, 32'd0, 32'h08, "pend_src3");

        // two sources at equal priority: claims in ID order, then none
        irq_src = 8'h00;
        xact(1'b1, 12'h00C, 32'd4, 32'd0, "w_prio3_4");
        xact(1'b1, 12'h014, 32'd4, 32'd0, "w_prio5_4");
        xact(1'b1, 12'h100, 32'h28, 32'd0, "w_en0_28");
        irq_src = 8'h10;
        tick();
        irq_src = 8'h00;
        tick();
        xact(1'b0, 12'h080, 32'd0, 32'h28, "pend_3_5");
        xact(1'b0, 12'h204, 32'd0, 32'd3, "claim_3");
        chk("meip_after_claim3", 32'(intr_meip), 32'd1);
        xact(1'b0, 12'h204, 32'd0, 32'd5, "claim_5");
        chk("meip_after_claim5", 32'(intr_meip), 32'd0);
        xact(1'b0, 12'h204, 32'd0, 32'd0, "claim_none");
        xact(1'b0, 12'h080, 32'd0, 32'h00, "pend_none");

        // completion with the source still high re-pends on the following edge
        irq_src = 8'h04;
        xact(1'b1, 12'h204, 32'd3, 32'd0, "complete_3");
        chk("meip_cmpl_e1", 32'(intr_meip), 32'd0);
        tick();
        chk("meip_cmpl_e2", 32'(intr_meip), 32'd1);
        xact(1'b0, 12'h080, 32'd0, 32'h08, "pend_repend3");
        xact(1'b1, 12'h204, 32'd6, 32'd0, "complete_6");
        xact(1'b0, 12'h080, 32'd0, 32'h08, "pend_after_c6");
        chk("meip_after_c6", 32'(intr_meip), 32'd1);
        xact(1'b1, 12'h304, 32'd5, 32'd0, "complete_5_ctx1");
        irq_src = 8'h14;
        tick();
        irq_src = 8'h04;
        tick();
        xact(1'b0, 12'h080, 32'd0, 32'h28, "pend_5_idle_again");

        // threshold gates priority equal to it
        xact(1'b1, 12'h200, 32'd4, 32'd0, "w_thr0_4");
        chk("meip_thr4", 32'(intr_meip), 32'd0);
        xact(1'b1, 12'h200, 32'd3, 32'd0, "w_thr0_3");
        chk("meip_thr3", 32'(intr_meip), 32'd1);

        // response backpressure with a second request waiting
        exp_q.push_back(32'd3);
        nm_q.push_back("stall_rdata_final");
        exp_q.push_back(32'd2);
        nm_q.push_back("after_stall_rdata");
        reg_req_vld  = 1'b1;
        reg_req_wr   = 1'b0;
        reg_req_addr = 12'h200;
        reg_rsp_rdy  = 1'b0;
        tick();
        reg_req_addr = 12'h300;
        for (int k = 0; k < 5; k++) begin
            chk("stall_rsp_vld", 32'(reg_rsp_vld), 32'd1);
            chk("stall_req_rdy", 32'(reg_req_rdy), 32'd0);
            chk("stall_rdata", reg_rsp_rdata, 32'd3);
            tick();
        end
        sb_pop_chk();
        reg_rsp_rdy = 1'b1;
        tick();
        chk("stall_release_vld", 32'(reg_rsp_vld), 32'd0);
        tick();
        reg_req_vld = 1'b0;
        chk("next_req_vld", 32'(reg_rsp_vld), 32'd1);
        sb_pop_chk();
        tick();

        // reset during an outstanding response
        chk("meip_pre_rst", 32'(intr_meip), 32'd1);
        reg_req_vld  = 1'b1;
        reg_req_addr = 12'h080;
        reg_rsp_rdy  = 1'b0;
        tick();
        reg_req_vld = 1'b0;
        chk("pre_rst_rsp_vld", 32'(reg_rsp_vld), 32'd1);
        irq_src = 8'h00;
        rst_n   = 1'b0;
        #1;
        chk("arst_meip", 32'(intr_meip), 32'd0);
        chk("arst_seip", 32'(intr_seip), 32'd0);
        chk("arst_rsp_vld", 32'(reg_rsp_vld), 32'd0);
        chk("arst_rdata", reg_rsp_rdata, 32'd0);
        chk("arst_req_rdy", 32'(reg_req_rdy), 32'd1);
        tick();
        rst_n       = 1'b1;
        reg_rsp_rdy = 1'b1;
        repeat (3) tick();
        chk("post_rst_no_replay", 32'(reg_rsp_vld), 32'd0);
        chk("post_rst_meip", 32'(intr_meip), 32'd0);
        xact(1'b0, 12'h080, 32'd0, 32'h00, "post_rst_pend");
        xact(1'b0, 12'h100, 32'd0, 32'h00, "post_rst_en0");
        xact(1'b0, 12'h00C, 32'd0, 32'h00, "post_rst_prio3");
        xact(1'b0, 12'h200, 32'd0, 32'h00, "post_rst_thr0");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
